// File: rtl/main_memory_pkg.sv
// ============================================================================
// Package     : main_memory_pkg
// Description : Shared types and helpers for the main_memory block-fill model:
//               FSM state encoding and the never-written block data pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package main_memory_pkg;

    // Widest block the pattern helper can describe; callers size-cast down.
    localparam int PKG_MAX_BLOCK_BITS = 1024;
    localparam int PKG_MAX_BYTES      = PKG_MAX_BLOCK_BITS / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mm_state_t;

    // Contents of a block that has never been written: byte j of block blk
    // holds the low 8 bits of its own byte address (blk*nbytes + j).
    function automatic logic [PKG_MAX_BLOCK_BITS-1:0] pattern_block(
        input int unsigned blk,
        input int unsigned nbytes
    );
        logic [PKG_MAX_BLOCK_BITS-1:0] res;
        res = '0;
        for (int j = 0; j < PKG_MAX_BYTES; j++) begin
            if (unsigned'(j) < nbytes) begin
                res[j*8 +: 8] = 8'((blk * nbytes) + unsigned'(j));
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_latency_timer.sv
// ============================================================================
// Module      : mem_latency_timer
// Description : Request latency counter. start loads 1, the count then
//               advances every cycle; done flags count == DELAY-1. abort
//               returns the counter to its idle value of 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_latency_timer #(
    parameter int DELAY = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic abort,
    output logic done
);

    localparam int COUNTER_SIZE = $clog2(DELAY + 1);
    localparam logic [COUNTER_SIZE-1:0] C_LAST = COUNTER_SIZE'(DELAY - 1);

    logic [COUNTER_SIZE-1:0] count_q;

    // Zero means idle; a running count never wraps because the owner aborts at done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (abort) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= COUNTER_SIZE'(1);
        end else if (count_q != '0) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign done = (count_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/main_memory.sv
// ============================================================================
// Module      : main_memory
// Description : Lower-level memory behind the direct-mapped cache. Accepts a
//               miss strobe in IDLE, waits DELAY cycles, then returns a whole
//               block with a one-cycle req_out pulse.
//               Optional block writes are built when MAIN_MEMORY_WRITE_EN is
//               defined; otherwise every request is a read of the fixed
//               address pattern and we_in / wdata_in are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_memory
    import main_memory_pkg::*;
#(
    parameter int ADDR_LENGTH = 10,
    parameter int BLOCK_SIZE  = 32,
    parameter int DELAY       = 50
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   miss_in,
    input  logic [ADDR_LENGTH-1:0] addr_in,
    input  logic                   we_in,
    input  logic [BLOCK_SIZE-1:0]  wdata_in,
    output logic [BLOCK_SIZE-1:0]  data_out,
    output logic                   req_out,
    output logic                   busy_out
);

    localparam int BYTES            = BLOCK_SIZE / 8;
    localparam int BYTE_SELECT_SIZE = $clog2(BYTES);
    localparam int NUM_BLOCKS       = 2 ** (ADDR_LENGTH - BYTE_SELECT_SIZE);
    localparam int BLK_W            = ADDR_LENGTH - BYTE_SELECT_SIZE;

    mm_state_t               state_q;
    logic [BLK_W-1:0]        blk_q;
    logic [BLOCK_SIZE-1:0]   data_q;
    logic                    req_q;
    logic                    busy_q;
    logic [BLOCK_SIZE-1:0]   data_d;
    logic [BLOCK_SIZE-1:0]   w_pattern;
    logic                    w_start;
    logic                    w_done;
    logic                    w_resp_edge;
    logic                    w_unused;

`ifdef MAIN_MEMORY_WRITE_EN
    logic                    we_q;
    logic [BLOCK_SIZE-1:0]   wdata_q;
    logic [BLOCK_SIZE-1:0]   mem_q [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0]   written_q;
`endif

    assign w_start     = (state_q == IDLE) && miss_in;
    assign w_resp_edge = (state_q == WAIT) && w_done;

    mem_latency_timer #(
        .DELAY (DELAY)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .abort (w_resp_edge),
        .done  (w_done)
    );

    assign w_pattern = BLOCK_SIZE'(pattern_block(32'(blk_q), BYTES));

`ifdef MAIN_MEMORY_WRITE_EN
    assign w_unused = ^addr_in[BYTE_SELECT_SIZE-1:0];
`else
    assign w_unused = ^{we_in, wdata_in, addr_in[BYTE_SELECT_SIZE-1:0]};
`endif

    // Block presented at the response edge: write data echo, stored word, or pattern.
    always_comb begin
        data_d = w_pattern;
`ifdef MAIN_MEMORY_WRITE_EN
        if (we_q) begin
            data_d = wdata_q;
        end else if (written_q[blk_q]) begin
            data_d = mem_q[blk_q];
        end
`endif
    end

    // Request FSM: accept in IDLE, count in WAIT, pulse req_out in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            blk_q   <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MAIN_MEMORY_WRITE_EN
            we_q    <= 1'b0;
            wdata_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_in) begin
                        blk_q   <= addr_in[ADDR_LENGTH-1:BYTE_SELECT_SIZE];
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
`ifdef MAIN_MEMORY_WRITE_EN
                        we_q    <= we_in;
                        wdata_q <= wdata_in;
`endif
                    end
                end
                WAIT: begin
                    if (w_done) begin
                        data_q  <= data_d;
                        req_q   <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MAIN_MEMORY_WRITE_EN
    // Block storage: deliberately not reset, contents only matter once flagged written.
    always_ff @(posedge clk) begin
        if (w_resp_edge && we_q) begin
            mem_q[blk_q] <= wdata_q;
        end
    end

    // Written flags: reset clears them so blocks fall back to the pattern.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            written_q <= '0;
        end else if (w_resp_edge && we_q) begin
            written_q[blk_q] <= 1'b1;
        end
    end
`endif

    assign data_out = data_q;
    assign req_out  = req_q;
    assign busy_out = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_main_memory.sv
// ============================================================================
// Module      : tb_main_memory
// Description : Self-checking bench for main_memory with a behavioural model
//               of block contents (pattern / written words) and latency.
//               Expectations follow MAIN_MEMORY_WRITE_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_memory;

    localparam int ADDR_LENGTH = 10;
    localparam int BLOCK_SIZE  = 32;
    localparam int DELAY       = 50;

    logic                   clk;
    logic                   reset;
    logic                   miss_in;
    logic [ADDR_LENGTH-1:0] addr_in;
    logic                   we_in;
    logic [BLOCK_SIZE-1:0]  wdata_in;
    logic [BLOCK_SIZE-1:0]  data_out;
    logic                   req_out;
    logic                   busy_out;

    int checks   = 0;
    int failures = 0;

    // Reference model: 256 blocks of 4 bytes.
    logic [31:0] m_mem [256];
    bit          m_wr  [256];

    main_memory #(
        .ADDR_LENGTH (ADDR_LENGTH),
        .BLOCK_SIZE  (BLOCK_SIZE),
        .DELAY       (DELAY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .miss_in  (miss_in),
        .addr_in  (addr_in),
        .we_in    (we_in),
        .wdata_in (wdata_in),
        .data_out (data_out),
        .req_out  (req_out),
        .busy_out (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_pattern(input int blk);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) begin
            r[8*j +: 8] = 8'((blk * 4 + j) % 256);
        end
        return r;
    endfunction

    // Model outcome of one request, updating stored state for writes.
    function automatic logic [31:0] ref_request(input logic [9:0] a, input logic we,
                                                input logic [31:0] wd);
        int blk;
        blk = int'(a) / 4;
`ifdef MAIN_MEMORY_WRITE_EN
        if (we) begin
            m_mem[blk] = wd;
            m_wr[blk]  = 1'b1;
            return wd;
        end
        return m_wr[blk] ? m_mem[blk] : ref_pattern(blk);
`else
        return ref_pattern(blk);
`endif
    endfunction

    // Issue a request from an idle DUT; returns just after the accept edge E0.
    task automatic issue(input logic [9:0] a, input logic we, input logic [31:0] wd,
                         input string nm);
        miss_in  = 1'b1;
        addr_in  = a;
        we_in    = we;
        wdata_in = wd;
        @(posedge clk); #1;
        miss_in = 1'b0;
        checks++;
        if (busy_out !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy_at_accept: got %b want 1", nm, busy_out);
        end
    endtask

    // Follow edges E0+1 .. E0+DELAY; optionally pulse miss_in before edge pulse_at.
    task automatic wait_resp(input logic [31:0] exp, input string nm,
                             input int pulse_at, input logic [9:0] pulse_addr);
        int bad_req  = 0;
        int bad_busy = 0;
        int pulses   = 0;
        logic [31:0] got = '0;
        for (int k = 1; k <= DELAY; k++) begin
            if (pulse_at != 0 && k == pulse_at) begin
                miss_in = 1'b1;
                addr_in = pulse_addr;
            end
            @(posedge clk); #1;
            miss_in = 1'b0;
            if (req_out === 1'b1) begin
                pulses++;
                got = data_out;
            end
            if ((k == DELAY - 1) != (req_out === 1'b1)) bad_req++;
            if (k < DELAY && busy_out !== 1'b1) bad_busy++;
        end
        checks++;
        if (bad_req != 0 || pulses != 1) begin
            failures++;
            $display("FAIL %s_req_timing: got %0d pulses (%0d wrong cycles) want 1 at E0+%0d",
                     nm, pulses, bad_req, DELAY - 1);
        end
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s_data: got %h want %h", nm, got, exp);
        end
        checks++;
        if (bad_busy != 0 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy: got %0d bad cycles, final %b want 0 bad, final 0",
                     nm, bad_busy, busy_out);
        end
        checks++;
        if (data_out !== exp) begin
            failures++;
            $display("FAIL %s_data_hold: got %h want %h", nm, data_out, exp);
        end
    endtask

    task automatic do_req(input logic [9:0] a, input logic we, input logic [31:0] wd,
                          input string nm);
        logic [31:0] exp;
        exp = ref_request(a, we, wd);
        issue(a, we, wd, nm);
        wait_resp(exp, nm, 0, '0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (data_out !== '0 || req_out !== 1'b0 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got data=%h req=%b busy=%b want 0/0/0",
                     data_out, req_out, busy_out);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_out !== 1'b0 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got req=%b busy=%b want 0/0", req_out, busy_out);
        end
    endtask

    task automatic test_read();
        do_req(10'h001, 1'b0, 32'h0, "read_001");
        checks++;
        if (data_out !== 32'h03020100) begin
            failures++;
            $display("FAIL read_001_literal: got %h want 03020100", data_out);
        end
    endtask

    task automatic test_top_block();
        do_req(10'h3FD, 1'b0, 32'h0, "top_block");
        checks++;
        if (data_out !== 32'hFFFEFDFC) begin
            failures++;
            $display("FAIL top_block_literal: got %h want fffefdfc", data_out);
        end
    endtask

    // Miss during WAIT is dropped; back-to-back re-issue accepted at E0+DELAY+1.
    task automatic test_busy_drop();
        logic [31:0] exp;
        exp = ref_request(10'h020, 1'b0, 32'h0);
        issue(10'h020, 1'b0, 32'h0, "busy_drop");
        wait_resp(exp, "busy_drop", 10, 10'h044);
        exp = ref_request(10'h044, 1'b0, 32'h0);
        issue(10'h044, 1'b0, 32'h0, "reissue");
        wait_resp(exp, "reissue", 0, '0);
    endtask

    task automatic test_write();
        do_req(10'h004, 1'b1, 32'hDEADBEEF, "write_004");
        do_req(10'h007, 1'b0, 32'h0, "readback_007");
        checks++;
`ifdef MAIN_MEMORY_WRITE_EN
        if (data_out !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL readback_literal: got %h want deadbeef", data_out);
        end
`else
        if (data_out !== 32'h07060504) begin
            failures++;
            $display("FAIL readback_literal: got %h want 07060504", data_out);
        end
`endif
    endtask

    task automatic test_random();
        logic [9:0]  a;
        logic        we;
        logic [31:0] wd;
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 1) a = 10'(32'h100 + $urandom_range(0, 15));
            else            a = 10'($urandom_range(0, 1023));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            do_req(a, we, wd, "random");
        end
    endtask

    task automatic test_abort();
        int stray = 0;
        issue(10'h010, 1'b0, 32'h0, "abort");
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (busy_out !== 1'b0 || req_out !== 1'b0 || data_out !== '0) begin
            failures++;
            $display("FAIL abort_outputs: got data=%h req=%b busy=%b want 0/0/0",
                     data_out, req_out, busy_out);
        end
        for (int b = 0; b < 256; b++) m_wr[b] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < DELAY + 5; k++) begin
            @(posedge clk); #1;
            if (req_out !== 1'b0 || busy_out !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL abort_no_response: got %0d active cycles want 0", stray);
        end
        do_req(10'h004, 1'b0, 32'h0, "after_abort");
        checks++;
        if (data_out !== 32'h07060504) begin
            failures++;
            $display("FAIL after_abort_literal: got %h want 07060504", data_out);
        end
    endtask

    initial begin
        reset    = 1'b0;
        miss_in  = 1'b0;
        addr_in  = '0;
        we_in    = 1'b0;
        wdata_in = '0;
        for (int b = 0; b < 256; b++) begin
            m_mem[b] = '0;
            m_wr[b]  = 1'b0;
        end
        test_reset();
        test_read();
        test_top_block();
        test_busy_drop();
        test_write();
        test_random();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
